// File: rtl/xbar_nxm_pkg.sv
// Shared definitions for the N x M crossbar.
//   CMD_WR / CMD_RD : command encodings carried on mst_cmd / slv_cmd
//   idx_w()         : index width helper, never narrower than one bit
//   slv_state_e     : per-slave channel state
package pkg_xbar;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  // Bits needed to index n items; a single item still gets a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } slv_state_e;

endpackage

// File: rtl/xbar_rr_arb.sv
// Combinational round-robin picker used once per slave channel.
//   req   : request vector, one bit per master
//   ptr   : highest-priority index for this round
//   gnt_c : one-hot grant, all zero when nothing requests
//   idx_c : encoded index of the granted master
module xbar_rr_arb
  import pkg_xbar::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c
);

  logic          found;
  logic [IW-1:0] cand;

  // Scan from ptr upward, wrapping mod N; the first requester wins.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        gnt_c[cand] = 1'b1;
        idx_c       = cand;
      end
    end
  end

endmodule

// File: rtl/xbar_nxm.sv
// N-master x M-slave crossbar for single-beat read/write commands.
// The slave is chosen by the top SEL_W address bits. Each slave channel
// arbitrates round-robin, forwards one command at a time, and records read
// issuers in an in-order tag FIFO so responses return to the right master.
//   clk, rst_n                    : clock, async active-low reset
//   mst_req/cmd/addr/wdata        : master commands (held until mst_ack)
//   mst_ack, mst_resp, mst_rdata  : accept strobe, read-data-valid, read data
//   slv_req/cmd/addr/wdata        : registered commands to the slaves
//   slv_ack, slv_resp, slv_rdata  : slave accept, read-data-valid, read data
//   err                           : sticky, response with no outstanding read
module xbar_nxm
  import pkg_xbar::*;
#(
  parameter int unsigned N_MST  = 4,
  parameter int unsigned N_SLV  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_MST-1:0]          mst_req,
  input  logic [N_MST-1:0]          mst_cmd,
  input  logic [N_MST*ADDR_W-1:0]   mst_addr,
  input  logic [N_MST*DATA_W-1:0]   mst_wdata,
  output logic [N_MST-1:0]          mst_ack,
  output logic [N_MST-1:0]          mst_resp,
  output logic [N_MST*DATA_W-1:0]   mst_rdata,
  output logic [N_SLV-1:0]          slv_req,
  output logic [N_SLV-1:0]          slv_cmd,
  output logic [N_SLV*ADDR_W-1:0]   slv_addr,
  output logic [N_SLV*DATA_W-1:0]   slv_wdata,
  input  logic [N_SLV-1:0]          slv_ack,
  input  logic [N_SLV-1:0]          slv_resp,
  input  logic [N_SLV*DATA_W-1:0]   slv_rdata,
  output logic                      err
);

  localparam int unsigned SEL_W  = idx_w(N_SLV);
  localparam int unsigned MIDX_W = idx_w(N_MST);
  localparam int unsigned CNT_W  = idx_w(N_MST + 1);
  localparam logic [MIDX_W-1:0] LAST_MST = MIDX_W'(N_MST - 1);

  slv_state_e              state_q [N_SLV];
  slv_state_e              state_d [N_SLV];
  logic [MIDX_W-1:0]       ptr_q   [N_SLV];
  logic [MIDX_W-1:0]       ptr_d   [N_SLV];
  logic [MIDX_W-1:0]       gnt_q   [N_SLV];
  logic [MIDX_W-1:0]       gnt_d   [N_SLV];
  logic [MIDX_W-1:0]       tag_q   [N_SLV][N_MST];
  logic [MIDX_W-1:0]       tag_d   [N_SLV][N_MST];
  logic [MIDX_W-1:0]       wp_q    [N_SLV];
  logic [MIDX_W-1:0]       wp_d    [N_SLV];
  logic [MIDX_W-1:0]       rp_q    [N_SLV];
  logic [MIDX_W-1:0]       rp_d    [N_SLV];
  logic [CNT_W-1:0]        cnt_q   [N_SLV];
  logic [CNT_W-1:0]        cnt_d   [N_SLV];
  logic [N_SLV-1:0]        req_d;
  logic [N_SLV-1:0]        cmd_d;
  logic [N_SLV*ADDR_W-1:0] addr_d;
  logic [N_SLV*DATA_W-1:0] wdata_d;
  logic [N_MST-1:0]        pend_q;
  logic [N_MST-1:0]        pend_d;
  logic                    err_d;

  logic [N_MST-1:0]        elig    [N_SLV];
  logic [N_MST-1:0]        arb_oh  [N_SLV];
  logic [MIDX_W-1:0]       arb_idx [N_SLV];
  logic [MIDX_W-1:0]       head_c  [N_SLV];
  logic [N_SLV-1:0]        push_c;
  logic [N_SLV-1:0]        pop_c;

  // A master competes only for the slave its address selects, and a read
  // waits while that master already has a read outstanding.
  always_comb begin
    for (int j = 0; j < N_SLV; j++) begin
      elig[j] = '0;
      for (int i = 0; i < N_MST; i++) begin
        elig[j][i] = mst_req[i]
                   && (mst_addr[i*ADDR_W + ADDR_W - SEL_W +: SEL_W] == SEL_W'(j))
                   && !((mst_cmd[i] == CMD_RD) && pend_q[i]);
      end
    end
  end

  for (genvar j = 0; j < N_SLV; j++) begin : g_arb
    xbar_rr_arb #(
      .N  (N_MST),
      .IW (MIDX_W)
    ) u_arb (
      .req   (elig[j]),
      .ptr   (ptr_q[j]),
      .gnt_c (arb_oh[j]),
      .idx_c (arb_idx[j])
    );
  end

  // Tag FIFO push on an accepted read, pop on a response with a tag present.
  always_comb begin
    push_c = '0;
    pop_c  = '0;
    for (int j = 0; j < N_SLV; j++) begin
      head_c[j] = tag_q[j][rp_q[j]];
      push_c[j] = (state_q[j] == BUSY) && slv_ack[j] && (slv_cmd[j] == CMD_RD);
      pop_c[j]  = slv_resp[j] && (cnt_q[j] != '0);
    end
  end

  // Accept strobes and read data pass straight through to the owning master.
  always_comb begin
    mst_ack   = '0;
    mst_resp  = '0;
    mst_rdata = '0;
    for (int j = 0; j < N_SLV; j++) begin
      if ((state_q[j] == BUSY) && slv_ack[j]) begin
        mst_ack[gnt_q[j]] = 1'b1;
      end
      if (pop_c[j]) begin
        mst_resp[head_c[j]] = 1'b1;
        mst_rdata[int'(head_c[j])*DATA_W +: DATA_W] = slv_rdata[j*DATA_W +: DATA_W];
      end
    end
  end

  // Per-slave next state: grant in IDLE, hold the command in BUSY until ack.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    tag_d   = tag_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    req_d   = slv_req;
    cmd_d   = slv_cmd;
    addr_d  = slv_addr;
    wdata_d = slv_wdata;
    pend_d  = pend_q;
    err_d   = err;

    for (int j = 0; j < N_SLV; j++) begin
      // Responses first: a master's pending bit can be cleared and a
      // different master's set on the same cycle without conflict.
      if (pop_c[j]) begin
        pend_d[head_c[j]] = 1'b0;
        rp_d[j] = (rp_q[j] == LAST_MST) ? '0 : rp_q[j] + 1'b1;
      end else if (slv_resp[j]) begin
        err_d = 1'b1;
      end

      if (push_c[j]) begin
        tag_d[j][wp_q[j]] = gnt_q[j];
        wp_d[j] = (wp_q[j] == LAST_MST) ? '0 : wp_q[j] + 1'b1;
        pend_d[gnt_q[j]] = 1'b1;
      end

      cnt_d[j] = cnt_q[j] + CNT_W'(push_c[j]) - CNT_W'(pop_c[j]);

      case (state_q[j])
        IDLE: begin
          if (|arb_oh[j]) begin
            state_d[j] = BUSY;
            gnt_d[j]   = arb_idx[j];
            req_d[j]   = 1'b1;
            cmd_d[j]   = mst_cmd[arb_idx[j]];
            addr_d[j*ADDR_W +: ADDR_W]  = mst_addr[int'(arb_idx[j])*ADDR_W +: ADDR_W];
            wdata_d[j*DATA_W +: DATA_W] = mst_wdata[int'(arb_idx[j])*DATA_W +: DATA_W];
          end
        end
        BUSY: begin
          if (slv_ack[j]) begin
            state_d[j] = IDLE;
            req_d[j]   = 1'b0;
            ptr_d[j]   = (gnt_q[j] == LAST_MST) ? '0 : gnt_q[j] + 1'b1;
          end
        end
        default: state_d[j] = IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N_SLV; j++) begin
        state_q[j] <= IDLE;
        ptr_q[j]   <= '0;
        gnt_q[j]   <= '0;
        wp_q[j]    <= '0;
        rp_q[j]    <= '0;
        cnt_q[j]   <= '0;
        for (int i = 0; i < N_MST; i++) begin
          tag_q[j][i] <= '0;
        end
      end
      slv_req   <= '0;
      slv_cmd   <= '0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      pend_q    <= '0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      tag_q     <= tag_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      slv_req   <= req_d;
      slv_cmd   <= cmd_d;
      slv_addr  <= addr_d;
      slv_wdata <= wdata_d;
      pend_q    <= pend_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_xbar_nxm.sv
// Directed self-checking bench for xbar_nxm with 4 masters and 4 slaves.
module tb_xbar_nxm;

  localparam int unsigned N_MST = 4;
  localparam int unsigned N_SLV = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_MST-1:0]       mst_req;
  logic [N_MST-1:0]       mst_cmd;
  logic [N_MST*AW-1:0]    mst_addr;
  logic [N_MST*DW-1:0]    mst_wdata;
  logic [N_MST-1:0]       mst_ack;
  logic [N_MST-1:0]       mst_resp;
  logic [N_MST*DW-1:0]    mst_rdata;
  logic [N_SLV-1:0]       slv_req;
  logic [N_SLV-1:0]       slv_cmd;
  logic [N_SLV*AW-1:0]    slv_addr;
  logic [N_SLV*DW-1:0]    slv_wdata;
  logic [N_SLV-1:0]       slv_ack;
  logic [N_SLV-1:0]       slv_resp;
  logic [N_SLV*DW-1:0]    slv_rdata;
  logic                   err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  xbar_nxm #(
    .N_MST  (N_MST),
    .N_SLV  (N_SLV),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mst_req   (mst_req),
    .mst_cmd   (mst_cmd),
    .mst_addr  (mst_addr),
    .mst_wdata (mst_wdata),
    .mst_ack   (mst_ack),
    .mst_resp  (mst_resp),
    .mst_rdata (mst_rdata),
    .slv_req   (slv_req),
    .slv_cmd   (slv_cmd),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_ack   (slv_ack),
    .slv_resp  (slv_resp),
    .slv_rdata (slv_rdata),
    .err       (err)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_mst(input int i, input logic req, input logic cmd,
                         input logic [31:0] addr, input logic [31:0] wd);
    mst_req[i] = req;
    mst_cmd[i] = cmd;
    mst_addr[i*AW +: AW]  = addr;
    mst_wdata[i*DW +: DW] = wd;
  endtask

  function automatic logic [31:0] saddr(input int j);
    return slv_addr[j*AW +: AW];
  endfunction

  function automatic logic [31:0] mrdata(input int i);
    return mst_rdata[i*DW +: DW];
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    mst_wdata = '0;
    slv_ack   = '0;
    slv_resp  = '0;
    slv_rdata = '0;
    for (int i = 0; i < N_MST; i++) set_mst(i, 1'b1, 1'b0, 32'h10 + 32'(i), 32'h0);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      settle();
      n_checks++;
      if ({slv_req, slv_cmd, mst_ack, mst_resp, err} !== '0 || slv_addr !== '0 ||
          slv_wdata !== '0 || mst_rdata !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: slv_req=%b mst_ack=%b mst_resp=%b err=%b, all required 0",
                 slv_req, mst_ack, mst_resp, err);
      end
    end
    rst_n = 1'b1;
    settle();
    n_checks++;
    if (slv_req !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release_same_cycle: slv_req=%b required 0000", slv_req);
    end
    next_cycle();
    settle();
    n_checks++;
    if (slv_req !== 4'b0001 || saddr(0) !== 32'h10) begin
      n_fail++;
      $display("FAIL reset_first_grant: slv_req=%b addr0=%h required 0001/00000010", slv_req, saddr(0));
    end
    // Reset with a command in flight drops it.
    mst_req = '0;
    rst_n   = 1'b0;
    settle();
    n_checks++;
    if (slv_req !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async_drop: slv_req=%b required 0000", slv_req);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    settle();
    n_checks++;
    if (slv_req !== 4'b0000 || mst_resp !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_nothing_after: slv_req=%b mst_resp=%b required 0000/0000", slv_req, mst_resp);
    end
  endtask

  task automatic test_write();
    set_mst(0, 1'b1, 1'b1, 32'h0000_0004, 32'h11);
    settle();
    n_checks++;
    if (slv_req !== 4'b0000) begin
      n_fail++;
      $display("FAIL write_latency: slv_req=%b required 0000", slv_req);
    end
    next_cycle();
    settle();
    n_checks++;
    if (slv_req !== 4'b0001 || slv_cmd[0] !== 1'b1 || saddr(0) !== 32'h4 ||
        slv_wdata[31:0] !== 32'h11 || mst_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL write_fwd: req=%b cmd=%b addr=%h wdata=%h ack=%b required 0001/1/4/11/0000",
               slv_req, slv_cmd[0], saddr(0), slv_wdata[31:0], mst_ack);
    end
    next_cycle();
    settle();
    n_checks++;
    if (slv_req !== 4'b0001 || saddr(0) !== 32'h4 || mst_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL write_hold: req=%b addr=%h ack=%b required 0001/4/0000", slv_req, saddr(0), mst_ack);
    end
    next_cycle();
    slv_ack[0] = 1'b1;
    settle();
    n_checks++;
    if (mst_ack !== 4'b0001 || mst_resp !== 4'b0000) begin
      n_fail++;
      $display("FAIL write_ack: mst_ack=%b mst_resp=%b required 0001/0000", mst_ack, mst_resp);
    end
    next_cycle();
    slv_ack    = '0;
    mst_req[0] = 1'b0;
    settle();
    n_checks++;
    if (slv_req !== 4'b0000 || mst_resp !== 4'b0000 || mst_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL write_done: req=%b resp=%b ack=%b required 0000/0000/0000", slv_req, mst_resp, mst_ack);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    int waited;
    for (int i = 0; i < N_MST; i++) set_mst(i, 1'b1, 1'b0, 32'h8000_0000 + 32'(i), 32'h0);
    next_cycle();
    settle();
    for (int k = 0; k < N_MST; k++) begin
      exp    = 4'b0001 << k;
      waited = 0;
      while (!slv_req[2] && waited < 8) begin
        next_cycle();
        settle();
        waited++;
      end
      n_checks++;
      if (slv_req[2] !== 1'b1 || saddr(2) !== 32'h8000_0000 + 32'(k) || slv_cmd[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: req2=%b addr2=%h cmd2=%b required 1/%h/0",
                 k, slv_req[2], saddr(2), slv_cmd[2], 32'h8000_0000 + 32'(k));
      end
      slv_ack[2] = 1'b1;
      settle();
      n_checks++;
      if (mst_ack !== exp) begin
        n_fail++;
        $display("FAIL rr_ack_%0d: mst_ack=%b required %b", k, mst_ack, exp);
      end
      next_cycle();
      slv_ack[2] = 1'b0;
      mst_req[k] = 1'b0;
      slv_resp[2] = 1'b1;
      slv_rdata[2*DW +: DW] = 32'hA0 + 32'(k);
      settle();
      n_checks++;
      if (mst_resp !== exp || mrdata(k) !== 32'hA0 + 32'(k)) begin
        n_fail++;
        $display("FAIL rr_resp_%0d: mst_resp=%b rdata=%h required %b/%h",
                 k, mst_resp, mrdata(k), exp, 32'hA0 + 32'(k));
      end
      next_cycle();
      slv_resp = '0;
      settle();
    end
    // Pointer wrapped back to 0: M0 must beat M3.
    set_mst(0, 1'b1, 1'b1, 32'h8000_0100, 32'h1);
    set_mst(3, 1'b1, 1'b1, 32'h8000_0103, 32'h2);
    next_cycle();
    settle();
    n_checks++;
    if (slv_req[2] !== 1'b1 || saddr(2) !== 32'h8000_0100) begin
      n_fail++;
      $display("FAIL rr_ptr_wrap: req2=%b addr2=%h required 1/80000100", slv_req[2], saddr(2));
    end
    slv_ack[2] = 1'b1;
    next_cycle();
    slv_ack[2] = 1'b0;
    mst_req[0] = 1'b0;
    next_cycle();
    settle();
    n_checks++;
    if (slv_req[2] !== 1'b1 || saddr(2) !== 32'h8000_0103) begin
      n_fail++;
      $display("FAIL rr_second: req2=%b addr2=%h required 1/80000103", slv_req[2], saddr(2));
    end
    slv_ack[2] = 1'b1;
    next_cycle();
    slv_ack[2] = 1'b0;
    mst_req[3] = 1'b0;
    next_cycle();
  endtask

  task automatic test_parallel();
    set_mst(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    set_mst(2, 1'b1, 1'b0, 32'hC000_0020, 32'h0);
    next_cycle();
    settle();
    n_checks++;
    if (slv_req !== 4'b1001 || saddr(0) !== 32'h10 || saddr(3) !== 32'hC000_0020) begin
      n_fail++;
      $display("FAIL par_grant: req=%b addr0=%h addr3=%h required 1001/10/c0000020",
               slv_req, saddr(0), saddr(3));
    end
    slv_ack = 4'b1001;
    settle();
    n_checks++;
    if (mst_ack !== 4'b0110) begin
      n_fail++;
      $display("FAIL par_ack: mst_ack=%b required 0110", mst_ack);
    end
    next_cycle();
    slv_ack  = '0;
    mst_req  = '0;
    slv_resp = 4'b1001;
    slv_rdata[0*DW +: DW] = 32'h1111;
    slv_rdata[3*DW +: DW] = 32'h3333;
    settle();
    n_checks++;
    if (mst_resp !== 4'b0110 || mrdata(1) !== 32'h1111 || mrdata(2) !== 32'h3333) begin
      n_fail++;
      $display("FAIL par_resp: resp=%b rd1=%h rd2=%h required 0110/1111/3333",
               mst_resp, mrdata(1), mrdata(2));
    end
    next_cycle();
    slv_resp = '0;
  endtask

  task automatic test_pending();
    set_mst(0, 1'b1, 1'b0, 32'h4000_0008, 32'h0);
    next_cycle();
    settle();
    n_checks++;
    if (slv_req !== 4'b0010 || saddr(1) !== 32'h4000_0008) begin
      n_fail++;
      $display("FAIL pend_first: req=%b addr1=%h required 0010/40000008", slv_req, saddr(1));
    end
    slv_ack[1] = 1'b1;
    next_cycle();
    slv_ack[1] = 1'b0;
    set_mst(0, 1'b1, 1'b0, 32'hC000_000C, 32'h0);
    for (int c = 1; c < 5; c++) begin
      settle();
      n_checks++;
      if (slv_req[3] !== 1'b0) begin
        n_fail++;
        $display("FAIL pend_block_%0d: req3=%b required 0", c, slv_req[3]);
      end
      next_cycle();
    end
    slv_resp[1] = 1'b1;
    slv_rdata[1*DW +: DW] = 32'h55;
    settle();
    n_checks++;
    if (mst_resp !== 4'b0001 || mrdata(0) !== 32'h55 || slv_req[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_resp: resp=%b rd0=%h req3=%b required 0001/55/0", mst_resp, mrdata(0), slv_req[3]);
    end
    next_cycle();
    slv_resp = '0;
    settle();
    n_checks++;
    if (slv_req[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_release_latency: req3=%b required 0", slv_req[3]);
    end
    next_cycle();
    settle();
    n_checks++;
    if (slv_req[3] !== 1'b1 || saddr(3) !== 32'hC000_000C) begin
      n_fail++;
      $display("FAIL pend_second: req3=%b addr3=%h required 1/c000000c", slv_req[3], saddr(3));
    end
    slv_ack[3] = 1'b1;
    settle();
    n_checks++;
    if (mst_ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL pend_second_ack: mst_ack=%b required 0001", mst_ack);
    end
    next_cycle();
    slv_ack  = '0;
    mst_req  = '0;
    slv_resp[3] = 1'b1;
    slv_rdata[3*DW +: DW] = 32'h77;
    settle();
    n_checks++;
    if (mst_resp !== 4'b0001 || mrdata(0) !== 32'h77) begin
      n_fail++;
      $display("FAIL pend_second_resp: resp=%b rd0=%h required 0001/77", mst_resp, mrdata(0));
    end
    next_cycle();
    slv_resp = '0;
  endtask

  task automatic test_err();
    settle();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_initial: err=%b required 0", err);
    end
    slv_resp[1] = 1'b1;
    slv_rdata[1*DW +: DW] = 32'hDEAD;
    settle();
    n_checks++;
    if (mst_resp !== 4'b0000 || mst_rdata !== '0) begin
      n_fail++;
      $display("FAIL err_no_resp: mst_resp=%b required 0000", mst_resp);
    end
    next_cycle();
    slv_resp = '0;
    settle();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: err=%b required 1", err);
    end
    repeat (3) next_cycle();
    settle();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b required 1", err);
    end
    rst_n = 1'b0;
    settle();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_reset: err=%b required 0", err);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_write();
    test_round_robin();
    test_parallel();
    test_pending();
    test_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/xbar_nxm.md
Name: xbar_nxm

Overview:
- Parametrised N-master x M-slave crossbar; next generation of the fixed 2x2 cross_bar.
- Routes single-beat read and write commands from any master to the slave selected by the top address bits.
- Per-slave round-robin arbitration.
- Read responses return to the issuing master through a per-slave in-order tag FIFO.
- Sits between master engines and slave memories/peripherals.

Parameters:
- N_MST, 4, number of masters (2..8).
- N_SLV, 4, number of slaves (power of two, 2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SEL_W, log2(N_SLV), derived slave-select width = addr[ADDR_W-1 -: SEL_W]; not overridable.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- mst_req  in  N_MST  per-master request; held until acked.
- mst_cmd  in  N_MST  1=write, 0=read.
- mst_addr  in  N_MST*ADDR_W  packed addresses, master i at slice i.
- mst_wdata  in  N_MST*DATA_W  packed write data.
- mst_ack  out  N_MST  one-cycle accept strobe.
- mst_resp  out  N_MST  one-cycle read-data-valid strobe.
- mst_rdata  out  N_MST*DATA_W  read data, valid with mst_resp.
- slv_req  out  N_SLV  request to slave.
- slv_cmd  out  N_SLV  forwarded cmd.
- slv_addr  out  N_SLV*ADDR_W  forwarded address, full width.
- slv_wdata  out  N_SLV*DATA_W  forwarded write data.
- slv_ack  in  N_SLV  slave accept strobe.
- slv_resp  in  N_SLV  read-data-valid from slave.
- slv_rdata  in  N_SLV*DATA_W  read data.
- err  out  1  sticky: response arrived with empty tag FIFO.

Behaviour:
Reset (rst_n low, asynchronous):
- All outputs 0; all RR pointers 0; all tag FIFOs empty; all pending-read bits clear; err 0.
- Reset mid-transaction drops everything in flight; no response is produced after release.

Eligibility:
- Master i is eligible for slave j when mst_req[i]=1, its select field = j, and NOT (mst_cmd[i]=0 and pend[i]=1).
- At most one outstanding read per master.

Per-slave state machine, IDLE -> BUSY -> IDLE:
- IDLE: if any master is eligible, pick the first eligible index at or after ptr[j] (wrapping mod N_MST).
  - Register gnt[j] and copy that master's cmd/addr/wdata to slv_* with slv_req[j]=1 at the next edge.
  - Request-to-slave latency: 1 cycle.
- BUSY: slv_* held stable while slv_req[j]=1.
  - mst_ack[gnt] = slv_ack[j], combinational, same cycle.
  - On slv_ack[j]: slv_req[j] drops at the next edge, ptr[j] <= gnt+1 mod N_MST, return to IDLE.
  - Minimum 2 cycles between grants on one slave.
  - If the command is a read: push gnt into tagfifo[j] and set pend[gnt].

Tag FIFO:
- Depth N_MST; cannot overflow because of the one-outstanding-read rule.
- On slv_resp[j]: pop head h; mst_resp[h]=1, mst_rdata[h]=slv_rdata[j], combinational, zero latency; clear pend[h] at the edge.
- slv_resp on an empty FIFO: ignored; err <= 1 (cleared only by reset).
- Push and pop on the same cycle: both take effect, count unchanged.

Simultaneous and boundary cases:
- No mst_resp collisions are possible: one pending read per master.
- Different slaves may grant different masters in the same cycle.
- One master never holds two grants, because its request targets exactly one slave.
- A master that deasserts mst_req before ack is a protocol violation; behaviour is undefined, with no assertion required.
- Writes produce no response.

Decomposition:
- Package pkg_xbar:
  - CMD_WR/CMD_RD constants;
  - clog2-based width helper;
  - per-slave state enum {IDLE, BUSY}.
- Sub-module xbar_rr_arb, instantiated once per slave:
  - inputs: request vector N_MST and pointer;
  - outputs: one-hot grant plus encoded index;
  - purely combinational.
- The tag FIFO stays inline as a small register array plus count.

Test Plan (defaults: N_MST=4, N_SLV=4):
1. Reset with rst_n low for 3 cycles, mst_req=4'hF -> all outputs 0 until release; first slv_req 1 cycle after release.
2. M0 writes 32'h11 to 32'h0000_0004 -> slv_req[0] next cycle with addr 32'h0000_0004 and wdata 32'h11; slave acks 2 cycles later -> mst_ack[0] in that same cycle; no mst_resp.
3. M0..M3 all read slave 2 (addr 32'h8000_0000+i), slave returns data 32'hA0+i one cycle after each ack -> grant order M0, M1, M2, M3; each master receives its own 32'hA0+i; ptr ends at 0.
4. M1 reads slave 0 while M2 reads slave 3 in the same cycle -> both granted in parallel; the responses route to M1 and M2 independently.
5. M0 reads slave 1 with the response delayed 5 cycles; M0 issues a second read to slave 3 meanwhile -> the second read is not forwarded until the first response, then proceeds.
6. slv_resp[1] pulsed with no outstanding read -> no mst_resp; err=1 and it stays 1 until reset.
